// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared op/state encodings and mod-13 counter constants for the counter sequencer
package count_seq_pkg;
    typedef enum logic [1:0] {OP_CLEAR = 2'b00, OP_LOAD = 2'b01, OP_UP = 2'b10, OP_DOWN = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
    localparam int CNT_MOD = 13;
    localparam logic [3:0] CNT_MAX = 4'(CNT_MOD - 1);
    function automatic logic [3:0] cnt_step(input logic [3:0] v, input logic up);
        return up ? ((v == CNT_MAX) ? 4'd0 : v + 4'd1) : ((v == 4'd0) ? CNT_MAX : v - 4'd1);
    endfunction
endpackage

// File: rtl/count_seq_rr_arb.sv
// count_seq_rr_arb: round-robin arbiter; search starts one past the last grant and wraps at NUM_REQ
module count_seq_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
);
    typedef logic [IW:0] wide_t;
    typedef logic [IW-1:0] idx_t;
    idx_t last_d, last_q;
    wide_t k;
    logic found;
    // first requesting index after last_q wins; pointer moves only on an accepted grant
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        found = 1'b0;
        k = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = wide_t'({1'b0, last_q}) + wide_t'(i);
            k = (k >= wide_t'(NUM_REQ)) ? k - wide_t'(NUM_REQ) : k;
            if (!found && req[k[IW-1:0]]) begin
                found = 1'b1;
                gnt[k[IW-1:0]] = 1'b1;
                gnt_idx = k[IW-1:0];
            end
        end
        last_d = adv ? gnt_idx : last_q;
    end
    // last grant starts at NUM_REQ-1 so requester 0 has first priority
    always_ff @(posedge clk or negedge rst)
        if (!rst) last_q <= idx_t'(NUM_REQ - 1);
        else last_q <= last_d;
endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: round-robin command sequencer driving a mod-13 up/down counter.
// Define COUNT_SEQ_CHECK_EN to build the shadow-counter checker behind chk_err.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LEN_W = 4,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       cmd_valid,
    output logic [NUM_REQ-1:0]       cmd_ready,
    input  logic [NUM_REQ*2-1:0]     cmd_op,
    input  logic [NUM_REQ*4-1:0]     cmd_data,
    input  logic [NUM_REQ*LEN_W-1:0] cmd_len,
    output logic                     rsp_valid,
    output logic [IW-1:0]            rsp_id,
    output logic [3:0]               rsp_count,
    output logic                     rsp_err,
    output logic                     cnt_rst,
    output logic                     cnt_mode,
    output logic                     cnt_load,
    output logic [3:0]               cnt_data_in,
    input  logic [3:0]               cnt_count,
    output logic                     chk_err
);
    state_e state_d, state_q;
    op_e op_d, op_q;
    logic [3:0] data_d, data_q;
    logic [LEN_W-1:0] len_d, len_q;
    logic [IW-1:0] id_d, id_q, gnt_idx;
    logic [NUM_REQ-1:0] req, gnt;
    logic hs, hold, bad_load;

    assign req = (state_q == S_IDLE) ? cmd_valid : '0;
    assign cmd_ready = rst ? gnt : '0;
    assign hs = |cmd_ready;

    count_seq_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .clk(clk), .rst(rst), .req(req), .adv(hs), .gnt(gnt), .gnt_idx(gnt_idx)
    );

    // latch the winning command, count down the run length and sequence IDLE/EXEC/DONE
    always_comb begin
        bad_load = op_q == OP_LOAD && data_q > CNT_MAX;
        state_d = state_q;
        op_d = op_q;
        data_d = data_q;
        len_d = len_q;
        id_d = id_q;
        if (state_q == S_IDLE && hs) begin
            op_d = op_e'(cmd_op[gnt_idx*2 +: 2]);
            data_d = cmd_data[gnt_idx*4 +: 4];
            len_d = cmd_len[gnt_idx*LEN_W +: LEN_W];
            id_d = gnt_idx;
            state_d = (op_d[1] && len_d == '0) ? S_DONE : S_EXEC;
        end else if (state_q == S_EXEC) begin
            len_d = len_q - 1'b1;
            state_d = (!op_q[1] || len_q == LEN_W'(1)) ? S_DONE : S_EXEC;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    // counter controls decoded from state and latched command; outside EXEC the counter reloads itself
    always_comb begin
        hold = state_q != S_EXEC || bad_load;
        cnt_rst = !rst || (state_q == S_EXEC && op_q == OP_CLEAR);
        cnt_load = rst && (hold || op_q == OP_LOAD);
        cnt_mode = !(rst && state_q == S_EXEC && op_q == OP_DOWN);
        cnt_data_in = !rst ? 4'd0 : hold ? cnt_count : (op_q == OP_LOAD) ? data_q : 4'd0;
        rsp_valid = rst && state_q == S_DONE;
        rsp_id = rsp_valid ? id_q : '0;
        rsp_count = rsp_valid ? cnt_count : 4'd0;
        rsp_err = rsp_valid && bad_load;
    end

    // sequencer state and latched command
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= S_IDLE;
            op_q <= OP_CLEAR;
            data_q <= '0;
            len_q <= '0;
            id_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            data_q <= data_d;
            len_q <= len_d;
            id_q <= id_d;
        end

`ifdef COUNT_SEQ_CHECK_EN
    logic [3:0] shadow_d, shadow_q;
    logic chk_d, chk_q;
    // mirror every drive into a mod-13 shadow and flag any divergence from the real counter
    always_comb begin
        shadow_d = cnt_rst ? 4'd0 : hold ? shadow_q : cnt_load ? cnt_data_in : cnt_step(shadow_q, cnt_mode);
        chk_d = chk_q || shadow_q != cnt_count;
    end
    // shadow value and sticky mismatch flag
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            shadow_q <= '0;
            chk_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            chk_q <= chk_d;
        end
    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed and randomized checks of count_seq_ctrl against a command-level model
`timescale 1ns/1ps
module tb_count_seq_ctrl;
    localparam int N = 2;
    localparam int LW = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] v = '0;
    logic [1:0] o [N];
    logic [3:0] dt [N];
    logic [LW-1:0] ln [N];
    logic [N*2-1:0] cmd_op;
    logic [N*4-1:0] cmd_data;
    logic [N*LW-1:0] cmd_len;
    logic [N-1:0] cmd_ready;
    logic rsp_valid, rsp_err, cnt_rst, cnt_mode, cnt_load, chk_err;
    logic [0:0] rsp_id;
    logic [3:0] rsp_count, cnt_data_in, cnt_count;
    logic [3:0] cnt_q = 4'd5;
    logic glitch = 1'b0;
    logic glitched = 1'b0;
    logic exp_chk = 1'b0;
    logic [N-1:0] hs = '0;
    int n_chk = 0, n_fail = 0;
    int cyc = 0, m_cnt = 0, m_last = N - 1, w;
    bit pend = 0;
    int p_gc, p_due, p_id, p_cnt, p_err, p_len;
    logic [1:0] p_op;
    int r_cnt, r_id, r_err;
    int grants[$];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign cmd_op[g*2 +: 2] = o[g];
        assign cmd_data[g*4 +: 4] = dt[g];
        assign cmd_len[g*LW +: LW] = ln[g];
    end
    assign cnt_count = cnt_q ^ (glitch ? 4'd3 : 4'd0);

    count_seq_ctrl #(.NUM_REQ(N), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(v), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_count(rsp_count), .rsp_err(rsp_err), .cnt_rst(cnt_rst), .cnt_mode(cnt_mode),
        .cnt_load(cnt_load), .cnt_data_in(cnt_data_in), .cnt_count(cnt_count), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    // the mod-13 counter being controlled
    always @(posedge clk)
        cnt_q <= cnt_rst ? 4'd0 : cnt_load ? cnt_data_in :
                 cnt_mode ? ((cnt_q == 4'd12) ? 4'd0 : cnt_q + 4'd1) : ((cnt_q == 4'd0) ? 4'd12 : cnt_q - 4'd1);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) if (r[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    function automatic int step_n(input int c, input bit up, input int n);
        return up ? (c + n) % 13 : ((c - n) % 13 + 13) % 13;
    endfunction

    // command-level model: arbitration, response timing and counter value per command
    always @(negedge clk) begin
        hs = v & cmd_ready;
        if (!rst) begin
            pend = 0;
            m_cnt = 0;
            m_last = N - 1;
            check("rst_cnt_rst", cnt_rst, 1);
            check("rst_cnt_load", cnt_load, 0);
            check("rst_cnt_mode", cnt_mode, 1);
            check("rst_data_in", cnt_data_in, 0);
            check("rst_ready", cmd_ready, 0);
            check("rst_rsp", {rsp_valid, rsp_err, rsp_id, rsp_count}, 0);
            check("rst_chk_err", chk_err, 0);
        end else begin
            cyc++;
            check("chk_err", chk_err, exp_chk);
            if (pend) begin
                check("busy_ready", cmd_ready, 0);
                if (cyc == p_due) begin
                    check("rsp_valid", rsp_valid, 1);
                    check("rsp_id", rsp_id, p_id);
                    check("rsp_count", rsp_count, p_cnt);
                    check("rsp_err", rsp_err, p_err);
                    r_cnt = rsp_count;
                    r_id = rsp_id;
                    r_err = rsp_err;
                    m_cnt = p_cnt;
                    pend = 0;
                end else begin
                    check("rsp_early", rsp_valid, 0);
                    check("exec_rst", cnt_rst, p_op == 2'b00);
                    if (p_op[1]) begin
                        check("exec_cnt", cnt_count, step_n(m_cnt, !p_op[0], cyc - p_gc - 1));
                        check("exec_mode", cnt_mode, !p_op[0]);
                        check("exec_load", cnt_load, 0);
                    end
                end
            end else begin
                w = rr_pick(v, m_last);
                check("ready", cmd_ready, (w < 0) ? 0 : (1 << w));
                check("idle_rsp", rsp_valid, 0);
                check("hold_load", cnt_load, 1);
                check("hold_data", cnt_data_in, cnt_count);
                if (!glitched) check("hold_cnt", cnt_count, m_cnt);
                if (w >= 0) begin
                    pend = 1;
                    p_gc = cyc;
                    p_id = w;
                    p_op = o[w];
                    p_len = ln[w];
                    m_last = w;
                    grants.push_back(w);
                    p_err = (p_op == 2'b01 && dt[w] > 12) ? 1 : 0;
                    p_cnt = (p_op == 2'b00) ? 0 : (p_op == 2'b01) ? (p_err ? m_cnt : dt[w]) : step_n(m_cnt, !p_op[0], p_len);
                    p_due = cyc + (!p_op[1] ? 2 : (p_len == 0) ? 1 : p_len + 1);
                end
            end
        end
    end

    task automatic send(input int r, input logic [1:0] op, input logic [3:0] d, input logic [LW-1:0] l);
        logic got;
        o[r] = op;
        dt[r] = d;
        ln[r] = l;
        v[r] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            got = hs[r];
        end
        check("grant_wait", got, 1);
        v[r] = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < 100 && pend; i++) begin
            @(posedge clk);
            #1;
        end
        check("rsp_wait", pend, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        for (int r = 0; r < N; r++) begin
            o[r] = 2'b00;
            dt[r] = 4'd0;
            ln[r] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("init_cnt", cnt_count, 0);
        send(0, 2'b01, 4'd7, 4'd0);
        settle();
        check("tp_load7", r_cnt, 7);
        send(1, 2'b10, 4'd0, 4'd8);
        settle();
        check("tp_up8_cnt", r_cnt, 2);
        check("tp_up8_id", r_id, 1);
        send(0, 2'b01, 4'd1, 4'd0);
        settle();
        send(0, 2'b11, 4'd0, 4'd3);
        settle();
        check("tp_down3", r_cnt, 11);
        repeat (10) @(posedge clk);
        #1;
        check("tp_hold11", cnt_count, 11);
        base = grants.size();
        o[0] = 2'b00;
        o[1] = 2'b00;
        v = '1;
        for (int i = 0; i < 100 && grants.size() < base + 4; i++) begin
            @(posedge clk);
            #1;
        end
        v = '0;
        check("tp_clr_grants", grants.size() >= base + 4, 1);
        for (int i = 0; i < 4 && base + i < grants.size(); i++) check("tp_clr_alt", grants[base + i], (1 + i) % 2);
        settle();
        check("tp_clr_cnt", r_cnt, 0);
        send(1, 2'b01, 4'd14, 4'd0);
        settle();
        check("tp_err", r_err, 1);
        check("tp_err_cnt", r_cnt, 0);
        send(0, 2'b01, 4'd12, 4'd0);
        settle();
        check("tp_ok", r_err, 0);
        check("tp_ok_cnt", r_cnt, 12);
        send(0, 2'b10, 4'd0, 4'd0);
        settle();
        check("tp_len0", r_cnt, 12);
        for (int k = 0; k < 1500; k++) begin
            for (int r = 0; r < N; r++) begin
                if (v[r] && hs[r]) v[r] = 1'b0;
                else if (v[r] && $urandom_range(0, 15) == 0) v[r] = 1'b0;
                if (!v[r] && $urandom_range(0, 3) == 0) begin
                    o[r] = 2'($urandom);
                    dt[r] = 4'($urandom_range(0, 15));
                    ln[r] = LW'($urandom_range(0, 15));
                    v[r] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        v = '0;
        settle();
        send(0, 2'b10, 4'd0, 4'd10);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("tp_rst_cnt", cnt_count, 0);
        v = '1;
        o[0] = 2'b00;
        o[1] = 2'b00;
        for (int i = 0; i < 20 && hs == '0; i++) begin
            @(posedge clk);
            #1;
        end
        v = '0;
        check("tp_rr_after_rst", hs, 2'b01);
        settle();
`ifdef COUNT_SEQ_CHECK_EN
        glitch = 1'b1;
        glitched = 1'b1;
        @(posedge clk);
        #1 glitch = 1'b0;
        exp_chk = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("tp_chk_sticky", chk_err, 1);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
